// File: rtl/beep_tone_decoder.sv
// Buzzer tone decoder: measures the spacing of falling edges on tone_in and
// reports the matching musical note once it has been stable for STABLE_N periods.
module beep_tone_decoder #(
  parameter int CLK_PRE   = 50_000_000,
  parameter int TOL_SHIFT = 6,
  parameter int STABLE_N  = 4,
  parameter int TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        tone_in,
  output logic [3:0]  note,
  output logic        note_valid,
  output logic [17:0] period,
  output logic        locked
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(STABLE_N + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MEASURE = 2'd1;
  localparam logic [1:0] S_LOCKED  = 2'd2;

  function automatic int freq_of(input int n);
    case (n)
      1:       freq_of = 262;
      2:       freq_of = 294;
      3:       freq_of = 330;
      4:       freq_of = 349;
      5:       freq_of = 392;
      6:       freq_of = 440;
      7:       freq_of = 494;
      8:       freq_of = 523;
      9:       freq_of = 587;
      10:      freq_of = 659;
      11:      freq_of = 698;
      12:      freq_of = 784;
      13:      freq_of = 880;
      default: freq_of = 988;
    endcase
  endfunction

  logic          sync1_reg, sync2_reg, sync3_reg;
  logic          edge_pulse;
  logic [17:0]   cnt_reg;
  logic [TW-1:0] tmo_reg;
  logic [1:0]    state_reg;
  logic [3:0]    cand_reg;
  logic [RW-1:0] run_reg;
  logic [RW-1:0] run_next;
  logic [13:0]   match;
  logic [3:0]    cls;
  logic          tmo_hit;
  logic          clear_req;
  int            cnt_int;

  assign edge_pulse = sync3_reg & ~sync2_reg;
  assign cnt_int    = {14'd0, cnt_reg};
  assign tmo_hit    = (tmo_reg == TW'(TIMEOUT - 1));
  assign clear_req  = !en || (state_reg != S_IDLE && tmo_hit);
  assign locked     = (note != 4'd0);

  // One tolerance window per note; windows are fixed at elaboration.
  generate
    for (genvar gi = 0; gi < 14; gi++) begin : g_cls
      localparam int P   = CLK_PRE / freq_of(gi + 1);
      localparam int TOL = P >>> TOL_SHIFT;
      assign match[gi] = (cnt_int >= P - TOL) && (cnt_int <= P + TOL);
    end
  endgenerate

  // Descending scan so the lowest matching code wins.
  always_comb begin
    cls = 4'd0;
    for (int i = 13; i >= 0; i--) begin
      if (match[i]) cls = 4'(i + 1);
    end
    if (cnt_reg == '1) cls = 4'd0;
  end

  always_comb begin
    run_next = RW'(1);
    if (cls == cand_reg && run_reg != '0) begin
      run_next = (run_reg == RW'(STABLE_N)) ? run_reg : run_reg + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b1;
      sync2_reg  <= 1'b1;
      sync3_reg  <= 1'b1;
      cnt_reg    <= '0;
      tmo_reg    <= '0;
      state_reg  <= S_IDLE;
      cand_reg   <= 4'd0;
      run_reg    <= '0;
      note       <= 4'd0;
      note_valid <= 1'b0;
      period     <= '0;
    end else begin
      sync1_reg  <= tone_in;
      sync2_reg  <= sync1_reg;
      sync3_reg  <= sync2_reg;
      note_valid <= 1'b0;
      cnt_reg    <= edge_pulse ? 18'd1 : ((cnt_reg == '1) ? cnt_reg : cnt_reg + 18'd1);

      if (clear_req) begin
        state_reg <= S_IDLE;
        cand_reg  <= 4'd0;
        run_reg   <= '0;
        tmo_reg   <= '0;
        if (note != 4'd0 && !note_valid) begin
          note       <= 4'd0;
          note_valid <= 1'b1;
        end
      end else if (state_reg == S_IDLE) begin
        tmo_reg <= '0;
        // A clear that collided with a classification pulse finishes here.
        if (note != 4'd0 && !note_valid) begin
          note       <= 4'd0;
          note_valid <= 1'b1;
        end
        if (edge_pulse) state_reg <= S_MEASURE;
      end else begin
        tmo_reg <= edge_pulse ? '0 : tmo_reg + TW'(1);
        if (edge_pulse) begin
          period   <= cnt_reg;
          cand_reg <= cls;
          run_reg  <= run_next;
          if (run_next == RW'(STABLE_N) && cls != note) begin
            note       <= cls;
            note_valid <= 1'b1;
            state_reg  <= (cls != 4'd0) ? S_LOCKED : S_MEASURE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_beep_tone_decoder.sv
// Bench for beep_tone_decoder: edge-spacing vectors with a note_valid scoreboard,
// scaled clock (CLK_PRE/100) so every scenario fits a short run.
module tb_beep_tone_decoder;

  localparam int CLK_PRE = 500_000;
  localparam int TMO     = 5_000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        tone_in = 1'b1;
  logic [3:0]  note;
  logic        note_valid;
  logic [17:0] period;
  logic        locked;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int tx = 0;

  typedef struct {
    int          spacing;
    logic [3:0]  exp_note;
    logic [17:0] exp_period;
  } vec_t;

  typedef struct {
    logic [3:0] note;
    int         deadline;
  } exp_t;

  vec_t tbl[19];
  exp_t sb_q[$];
  logic [3:0] model_note = 4'd0;
  logic prev_nv = 1'b0;

  beep_tone_decoder #(
    .CLK_PRE(CLK_PRE), .TOL_SHIFT(6), .STABLE_N(4), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tone_in(tone_in),
    .note(note), .note_valid(note_valid), .period(period), .locked(locked)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every note_valid pulse must match the oldest expected change.
  always @(negedge clk) begin
    if (note_valid) begin
      check("nv_not_consecutive", int'(prev_nv), 0);
      if (sb_q.size() == 0) begin
        check("unexpected_note_valid_note", int'(note), -1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_note", int'(note), int'(e.note));
        check("pulse_in_time", int'(cyc <= e.deadline), 1);
        $display("pulse: note=%0d period=%0d cycle=%0d", note, period, cyc);
      end
    end
    prev_nv <= note_valid;
  end

  // Falls on tone_in are exactly 'spacing' cycles apart across consecutive calls.
  task automatic send_edge(input int spacing, input logic [3:0] exp_note);
    repeat (spacing - 4) @(negedge clk);
    if (exp_note != model_note) begin
      exp_t e;
      e.note = exp_note;
      e.deadline = cyc + 5;
      sb_q.push_back(e);
      model_note = exp_note;
    end
    tone_in = 1'b0;
    repeat (4) @(negedge clk);
    tone_in = 1'b1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] exp_note);
    check({tag, "_note"}, int'(note), int'(exp_note));
    check({tag, "_locked"}, int'(locked), int'(exp_note != 4'd0));
  endtask

  task automatic lock_mi();
    send_edge(100, 4'd0);
    for (int i = 0; i < 3; i++) send_edge(758, 4'd0);
    send_edge(758, 4'd10);
    check_state("lock_mi", 4'd10);
    check("lock_mi_period", int'(period), 758);
  endtask

  initial begin
    #(2_000_000 * 10);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{100, 4'd0, 18'd0};
    tbl[1]  = '{758, 4'd0, 18'd758};
    tbl[2]  = '{758, 4'd0, 18'd758};
    tbl[3]  = '{758, 4'd0, 18'd758};
    tbl[4]  = '{758, 4'd10, 18'd758};
    tbl[5]  = '{716, 4'd10, 18'd716};
    tbl[6]  = '{716, 4'd10, 18'd716};
    tbl[7]  = '{716, 4'd10, 18'd716};
    tbl[8]  = '{716, 4'd11, 18'd716};
    tbl[9]  = '{758, 4'd11, 18'd758};
    tbl[10] = '{758, 4'd11, 18'd758};
    tbl[11] = '{758, 4'd11, 18'd758};
    tbl[12] = '{758, 4'd10, 18'd758};
    for (int i = 13; i < 19; i++) begin
      tbl[i].spacing    = (i % 2 == 1) ? 769 : 758;
      tbl[i].exp_note   = 4'd10;
      tbl[i].exp_period = 18'(tbl[i].spacing);
    end

    repeat (3) @(negedge clk);
    check("reset_note", int'(note), 0);
    check("reset_period", int'(period), 0);
    check("reset_valid", int'(note_valid), 0);
    check("reset_locked", int'(locked), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      send_edge(tbl[i].spacing, tbl[i].exp_note);
      tx++;
      $display("vec %0d: spacing=%0d note=%0d period=%0d locked=%0d", i, tbl[i].spacing, note, period, locked);
      check("vec_note", int'(note), int'(tbl[i].exp_note));
      check("vec_period", int'(period), int'(tbl[i].exp_period));
      check("vec_locked", int'(locked), int'(tbl[i].exp_note != 4'd0));
    end
    check("vec_queue_drained", sb_q.size(), 0);

    // Silence: note drops TIMEOUT cycles after the last edge.
    begin
      exp_t e;
      e.note = 4'd0;
      e.deadline = cyc - 4 + TMO + 6;
      sb_q.push_back(e);
      model_note = 4'd0;
    end
    repeat (TMO - 14) @(negedge clk);
    check_state("pre_timeout", 4'd10);
    repeat (30) @(negedge clk);
    check_state("post_timeout", 4'd0);
    check("timeout_queue_drained", sb_q.size(), 0);
    $display("timeout: note=%0d locked=%0d", note, locked);

    // Out-of-range spacing never produces a note or pulse.
    for (int i = 0; i < 5; i++) begin
      send_edge(2500, 4'd0);
      check_state("no_match", 4'd0);
      $display("no_match edge %0d: note=%0d period=%0d", i, note, period);
    end
    repeat (TMO + 500) @(negedge clk);
    check("no_match_queue_drained", sb_q.size(), 0);

    // Enable drop while locked clears the note with one pulse.
    lock_mi();
    begin
      exp_t e;
      e.note = 4'd0;
      e.deadline = cyc + 3;
      sb_q.push_back(e);
      model_note = 4'd0;
    end
    en = 1'b0;
    repeat (5) @(negedge clk);
    check_state("en_low", 4'd0);
    send_edge(758, 4'd0);
    check_state("en_low_edge_ignored", 4'd0);
    en = 1'b1;
    repeat (10) @(negedge clk);
    check("en_queue_drained", sb_q.size(), 0);
    $display("en_low: note=%0d locked=%0d", note, locked);

    // Asynchronous reset mid-tone, then relock needs STABLE_N+1 edges.
    lock_mi();
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    model_note = 4'd0;
    #1;
    check("rst_note", int'(note), 0);
    check("rst_period", int'(period), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_valid", int'(note_valid), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_edge((i == 0) ? 554 : 758, 4'd0);
      check_state("relock_pending", 4'd0);
    end
    send_edge(758, 4'd10);
    check_state("relock", 4'd10);
    check("relock_period", int'(period), 758);
    repeat (10) @(negedge clk);
    check("final_queue_drained", sb_q.size(), 0);
    $display("reset_relock: note=%0d period=%0d", note, period);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/beep_tone_decoder.md
BEEP_TONE_DECODER -- requirements
Module: beep_tone_decoder

Interface
REQ-001 SHALL have parameter CLK_PRE, default 50_000_000, clk frequency in Hz; nominal note periods P(n) = CLK_PRE / f(n), integer division.
REQ-002 SHALL have parameter TOL_SHIFT, default 6, match tolerance: |measured - P(n)| <= P(n) >> TOL_SHIFT.
REQ-003 SHALL have parameter STABLE_N, default 4, count of consecutive identical classifications needed to change the output.
REQ-004 SHALL have parameter TIMEOUT, default 1_000_000, clk cycles without a falling edge that mean silence.
REQ-005 SHALL have port clk  input  1  system clock.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  decoder enable; low forces IDLE.
REQ-008 SHALL have port tone_in  input  1  asynchronous buzzer-drive waveform, idle high, active-low pulses once per tone period.
REQ-009 SHALL have port note  output  4  decoded note code; 0 = silence or unknown.
REQ-010 SHALL have port note_valid  output  1  one-cycle pulse when note changes.
REQ-011 SHALL have port period  output  18  last measured period in clk cycles.
REQ-012 SHALL have port locked  output  1  high while note != 0.

Function
REQ-013 SHALL synchronise tone_in with two flops and detect falling edges on the synchronised signal; edge pulse 3 cycles after input transition.
REQ-014 SHALL use note codes 1..14 = 262,294,330,349,392,440,494,523,587,659,698,784,880,988 Hz, in that order.
REQ-015 SHALL use states IDLE, MEASURE, LOCKED; IDLE->MEASURE on first edge, MEASURE->LOCKED when note becomes nonzero, LOCKED->MEASURE when note returns to 0 via classification, any state->IDLE on timeout or en low.
REQ-016 SHALL, in IDLE, only arm the period counter on an edge; no period is measured from that edge.
REQ-017 SHALL, in MEASURE/LOCKED, load period with the clk-cycle distance between consecutive edge pulses on each edge.
REQ-018 SHALL saturate the period counter at 18 bits and classify a saturated measurement as 0.
REQ-019 SHALL classify each measured period to the lowest code n whose tolerance window contains it, else 0.
REQ-020 SHALL track candidate and a run count: same candidate as previous increments (saturating at STABLE_N); different candidate sets run count to 1.
REQ-021 SHALL, on the cycle run count reaches STABLE_N with candidate != note, load note with candidate and assert note_valid for exactly one cycle, 1 cycle after the classifying edge pulse.
REQ-022 SHALL treat candidate 0 the same way, so STABLE_N unmatched periods drive note to 0 with a note_valid pulse.
REQ-023 SHALL, when TIMEOUT cycles elapse since the last edge, enter IDLE, clear candidate history, and if note != 0 set note to 0 with one note_valid pulse.
REQ-024 SHALL, when en falls, behave as REQ-023 on the next cycle; edges while en low are ignored.
REQ-025 SHALL never assert note_valid on consecutive cycles nor when note is unchanged.

Reset
REQ-026 SHALL on rst_n low force state IDLE, note 0, note_valid 0, period 0, locked 0, counters and candidate history 0, synchroniser flops 1.
REQ-027 SHALL, on reset release mid-tone, need STABLE_N+1 edges before a nonzero note is output.

Verification
REQ-028 SHALL verify: 5 falling edges spaced 75872 cycles (659 Hz) -> note=10, single note_valid one cycle after 5th edge pulse, period=75872, locked=1.
REQ-029 SHALL verify: MI locked, then edges spaced 71633 (698 Hz) -> note stays 10 for 3 periods, becomes 11 on the 4th with one pulse.
REQ-030 SHALL verify: spacing alternating 75872 and 76872 (within 1185 tolerance) -> note remains 10, no further pulses.
REQ-031 SHALL verify: edges spaced 10000 cycles -> note stays 0, note_valid never asserted.
REQ-032 SHALL verify: MI locked, edges stop -> 1_000_000 cycles after last edge note=0, one note_valid pulse, locked=0.
REQ-033 SHALL verify: rst_n pulsed low while locked -> all outputs 0 immediately; relock needs 5 further edges.
